consola_enigma: RTL and testbench
=================================

CONSOLA_ENIGMA -- requirements
Module: consola_enigma

Interface
REQ-001 Parameter TXQ_DEPTH, default 16, TX byte queue depth; power of 2, minimum 4.
REQ-002 Parameter ALPHA, default 26, alphabet size; letter codes are 0..ALPHA-1 and map to "A"+code.
REQ-003 Parameter MAX_PAIRS, default 10, maximum number of plugboard pairs.
REQ-004 clk  in  1  single clock; all logic is on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rx_byte  in  8  received byte, valid while rx_done is high.
REQ-007 rx_done  in  1  one-cycle received-byte strobe.
REQ-008 tx_ready  in  1  UART transmitter idle and able to accept a byte.
REQ-009 tx_byte  out  8  byte to transmit.
REQ-010 tx_start  out  1  one-cycle transmit request.
REQ-011 enc_char_in  out  5  plugboarded letter sent to the cipher core.
REQ-012 enc_valid_in  out  1  one-cycle strobe that qualifies enc_char_in.
REQ-013 enc_char_out  in  5  cipher core result.
REQ-014 enc_valid_out  in  1  one-cycle result strobe, same clock domain.
REQ-015 enc_pos1, enc_pos2, enc_pos3  out  5 each  rotor start positions.
REQ-016 enc_load  out  1  one-cycle strobe that loads enc_pos1..3 into the core.
REQ-017 state_dbg  out  4  current FSM state code.
REQ-018 pair_count  out  4  number of active plugboard pairs.
REQ-019 tx_ovf  out  1  sticky TX-queue overflow flag.

Function
REQ-020 The FSM SHALL have exactly these states, with these codes: INIT 0, PRINT 1, MENU 2, PLUG_1 3, PLUG_2 4, ROT 5, CRYPT 6, CRYPT_WAIT 7.
REQ-021 The message ROM SHALL hold these strings: MENU = 0x0D 0x0A "MENU>"; PLUG = 0x0D 0x0A "PLUG:"; ROT = 0x0D 0x0A "ROT:"; CRYPT = 0x0D 0x0A "CRYPT:". Each string ends in a terminator that is not transmitted.
REQ-022 In PRINT, the block SHALL push one message byte per cycle into the TX queue while the queue is not full, stall while it is full, and on reaching the terminator go to the stored return state.
REQ-023 INIT SHALL select MENU with return state MENU and go to PRINT on the next cycle.
REQ-024 In MENU, rx_done with "P"/"p" SHALL print PLUG then enter PLUG_1; "R"/"r" SHALL print ROT then enter ROT; "S"/"s" SHALL print CRYPT then enter CRYPT; every other byte SHALL be ignored.
REQ-025 TX queue pop: when the queue is non-empty, tx_ready=1 and tx_start was 0 in the previous cycle, the block SHALL drive tx_byte from the queue head and pulse tx_start for 1 cycle.
REQ-026 An echo or "?" push into a full queue SHALL drop the byte and set tx_ovf; tx_ovf clears only on reset.
REQ-027 Letter input in PLUG_1, PLUG_2, ROT and CRYPT SHALL accept lowercase, folded to uppercase; any other non-letter byte SHALL be ignored unless listed below.
REQ-028 In PLUG_1, a letter L1 SHALL be rejected when plug[L1]!=L1 or pair_count==MAX_PAIRS: push "?" and stay. Otherwise the block SHALL echo L1 and go to PLUG_2.
REQ-029 In PLUG_2, a letter L2 SHALL be rejected when L2==L1 or plug[L2]!=L2: push "?" and return to PLUG_1. Otherwise the block SHALL echo L2, push " ", set plug[L1]=L2 and plug[L2]=L1, increment pair_count, and return to PLUG_1.
REQ-030 "." in PLUG_1 SHALL restore the identity plugboard and set pair_count=0. ESC (0x1B) in PLUG_1 or PLUG_2 SHALL go to INIT; a half-entered pair is discarded.
REQ-031 ROT SHALL collect three letters with an echo for each. After the third letter, enc_pos1..3 SHALL hold the letters in entry order, enc_load SHALL pulse in the same cycle the registers update, and the FSM SHALL go to INIT. ESC SHALL go to INIT with no load and positions unchanged.
REQ-032 In CRYPT, letter L SHALL drive enc_char_in=plug[L] and pulse enc_valid_in for 1 cycle, then the FSM SHALL go to CRYPT_WAIT. ESC SHALL go to INIT.
REQ-033 In CRYPT_WAIT, enc_valid_out SHALL cause a push of plug[enc_char_out]+"A" and a return to CRYPT; rx_done in this state SHALL be dropped, ESC included.
REQ-034 enc_valid_out outside CRYPT_WAIT SHALL be ignored.

Reset
REQ-035 rst SHALL force: state INIT; TX queue empty; tx_start=0, tx_byte=0; enc_valid_in=0, enc_char_in=0, enc_load=0; enc_pos1..3=0; identity plugboard; pair_count=0; tx_ovf=0.
REQ-036 rst asserted mid-print or mid-pair SHALL abort the operation; no queued byte is transmitted after reset.
REQ-037 After rst is released, the block SHALL print MENU without any input.

Verification
REQ-038 Release reset with tx_ready=1 -> tx_start bytes 0D 0A 4D 45 4E 55 3E in order; no two tx_start pulses on adjacent cycles; state_dbg=2.
REQ-039 Send "P","a","b" -> echo "A" "B" " "; pair_count=1. Then ESC, "S", "A" -> enc_char_in=1. Return enc_char_out=0 -> tx "B".
REQ-040 After pair AB, send "B" in PLUG_1 -> "?" transmitted, pair_count stays 1. Send "." -> pair_count=0, identity plugboard restored.
REQ-041 Send "R","Q","E","V" -> one enc_load pulse with enc_pos1/2/3 = 16/4/21, then MENU printed.
REQ-042 Hold tx_ready=0, enter PLUG_1, then send 20 alternating "A","?" bytes -> tx_ovf=1, no X state. Release tx_ready -> the queue drains exactly TXQ_DEPTH bytes.
REQ-043 Assert rst for 1 cycle during MENU printing -> tx_start stays 0 until a fresh MENU sequence starts from 0D.

Source files
------------

// File: rtl/consola_enigma.sv
// consola_enigma: UART console front-end for an Enigma cipher core.
// Menu FSM, message ROM, plugboard, rotor setup and a TX byte queue.
module consola_enigma #(
    parameter int TXQ_DEPTH = 16,
    parameter int ALPHA     = 26,
    parameter int MAX_PAIRS = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_done,
    input  logic       tx_ready,
    output logic [7:0] tx_byte,
    output logic       tx_start,
    output logic [4:0] enc_char_in,
    output logic       enc_valid_in,
    input  logic [4:0] enc_char_out,
    input  logic       enc_valid_out,
    output logic [4:0] enc_pos1,
    output logic [4:0] enc_pos2,
    output logic [4:0] enc_pos3,
    output logic       enc_load,
    output logic [3:0] state_dbg,
    output logic [3:0] pair_count,
    output logic       tx_ovf
);
    localparam int AW = $clog2(TXQ_DEPTH);
    localparam logic [7:0] ESC = 8'h1B;

    typedef enum logic [3:0] {
        INIT = 4'd0, PRINT = 4'd1, MENU = 4'd2, PLUG_1 = 4'd3,
        PLUG_2 = 4'd4, ROT = 4'd5, CRYPT = 4'd6, CRYPT_WAIT = 4'd7
    } state_t;
    typedef enum logic [1:0] {
        MSG_MENU, MSG_PLUG, MSG_ROT, MSG_CRYPT
    } msg_t;

    state_t        state_q, state_d, ret_q, ret_d;
    msg_t          msg_q, msg_d;
    logic [3:0]    idx_q, idx_d;
    logic [4:0]    l1_q, l1_d, rot_a_q, rot_a_d, rot_b_q, rot_b_d;
    logic [1:0]    rcnt_q, rcnt_d;
    logic [4:0]    pos1_q, pos1_d, pos2_q, pos2_d, pos3_q, pos3_d;
    logic          load_q, load_d, ev_q, ev_d;
    logic [4:0]    ec_q, ec_d;
    logic [3:0]    pair_q, pair_d;
    logic          ovf_q, ovf_d;
    logic [4:0]    plug_q [32];
    logic          plug_clr, plug_set;
    logic [7:0]    mem_q [TXQ_DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          txs_q;
    logic [7:0]    txb_q;
    logic          pa_v, pb_v, a_ok, b_ok, pop, full;
    logic [7:0]    pa_d, pb_d, rom_b, up_off, lo_off;
    logic          is_up, is_lo, let_v, esc;
    logic [4:0]    let_code;

    // Index 0/1 is CR LF for every message; 0x00 terminates.
    function automatic logic [7:0] rom(input msg_t m, input logic [3:0] i);
        logic [7:0] b;
        b = 8'h00;
        if (i == 4'd0) begin
            b = 8'h0D;
        end else if (i == 4'd1) begin
            b = 8'h0A;
        end else begin
            case (m)
                MSG_MENU:  case (i)
                    4'd2: b = "M"; 4'd3: b = "E"; 4'd4: b = "N";
                    4'd5: b = "U"; 4'd6: b = ">"; default: b = 8'h00;
                endcase
                MSG_PLUG:  case (i)
                    4'd2: b = "P"; 4'd3: b = "L"; 4'd4: b = "U";
                    4'd5: b = "G"; 4'd6: b = ":"; default: b = 8'h00;
                endcase
                MSG_ROT:   case (i)
                    4'd2: b = "R"; 4'd3: b = "O"; 4'd4: b = "T";
                    4'd5: b = ":"; default: b = 8'h00;
                endcase
                default:   case (i)
                    4'd2: b = "C"; 4'd3: b = "R"; 4'd4: b = "Y";
                    4'd5: b = "P"; 4'd6: b = "T"; 4'd7: b = ":";
                    default: b = 8'h00;
                endcase
            endcase
        end
        return b;
    endfunction

    assign rom_b    = rom(msg_q, idx_q);
    assign up_off   = rx_byte - 8'h41;
    assign lo_off   = rx_byte - 8'h61;
    assign is_up    = (rx_byte >= 8'h41) && (up_off < 8'(ALPHA));
    assign is_lo    = (rx_byte >= 8'h61) && (lo_off < 8'(ALPHA));
    assign let_code = is_up ? up_off[4:0] : lo_off[4:0];
    assign let_v    = rx_done && (is_up || is_lo);
    assign esc      = rx_done && (rx_byte == ESC);
    assign full     = cnt_q == (AW+1)'(TXQ_DEPTH);

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        msg_d    = msg_q;
        idx_d    = idx_q;
        l1_d     = l1_q;
        rot_a_d  = rot_a_q;
        rot_b_d  = rot_b_q;
        rcnt_d   = rcnt_q;
        pos1_d   = pos1_q;
        pos2_d   = pos2_q;
        pos3_d   = pos3_q;
        load_d   = 1'b0;
        ev_d     = 1'b0;
        ec_d     = ec_q;
        pair_d   = pair_q;
        plug_clr = 1'b0;
        plug_set = 1'b0;
        pa_v     = 1'b0;
        pa_d     = 8'h00;
        pb_v     = 1'b0;
        pb_d     = 8'h00;
        unique case (state_q)
            INIT: begin
                msg_d   = MSG_MENU;
                ret_d   = MENU;
                idx_d   = '0;
                state_d = PRINT;
            end
            PRINT: begin
                if (rom_b == 8'h00) begin
                    state_d = ret_q;
                end else if (!full) begin
                    pa_v  = 1'b1;
                    pa_d  = rom_b;
                    idx_d = idx_q + 4'd1;
                end
            end
            MENU: begin
                if (rx_done && (rx_byte == "P" || rx_byte == "p")) begin
                    msg_d = MSG_PLUG; ret_d = PLUG_1;
                    idx_d = '0; state_d = PRINT;
                end else if (rx_done && (rx_byte == "R" || rx_byte == "r")) begin
                    msg_d = MSG_ROT; ret_d = ROT; rcnt_d = '0;
                    idx_d = '0; state_d = PRINT;
                end else if (rx_done && (rx_byte == "S" || rx_byte == "s")) begin
                    msg_d = MSG_CRYPT; ret_d = CRYPT;
                    idx_d = '0; state_d = PRINT;
                end
            end
            PLUG_1: begin
                if (esc) begin
                    state_d = INIT;
                end else if (rx_done && rx_byte == ".") begin
                    plug_clr = 1'b1;
                    pair_d   = '0;
                end else if (let_v) begin
                    pa_v = 1'b1;
                    if (plug_q[let_code] != let_code ||
                        pair_q == 4'(MAX_PAIRS)) begin
                        pa_d = "?";
                    end else begin
                        pa_d    = 8'h41 + {3'b000, let_code};
                        l1_d    = let_code;
                        state_d = PLUG_2;
                    end
                end
            end
            PLUG_2: begin
                if (esc) begin
                    state_d = INIT;
                end else if (let_v) begin
                    pa_v    = 1'b1;
                    state_d = PLUG_1;
                    if (let_code == l1_q || plug_q[let_code] != let_code) begin
                        pa_d = "?";
                    end else begin
                        pa_d     = 8'h41 + {3'b000, let_code};
                        pb_v     = 1'b1;
                        pb_d     = " ";
                        plug_set = 1'b1;
                        pair_d   = pair_q + 4'd1;
                    end
                end
            end
            ROT: begin
                if (esc) begin
                    state_d = INIT;
                end else if (let_v) begin
                    pa_v   = 1'b1;
                    pa_d   = 8'h41 + {3'b000, let_code};
                    rcnt_d = rcnt_q + 2'd1;
                    if (rcnt_q == 2'd0) rot_a_d = let_code;
                    if (rcnt_q == 2'd1) rot_b_d = let_code;
                    if (rcnt_q == 2'd2) begin
                        pos1_d  = rot_a_q;
                        pos2_d  = rot_b_q;
                        pos3_d  = let_code;
                        load_d  = 1'b1;
                        state_d = INIT;
                    end
                end
            end
            CRYPT: begin
                if (esc) begin
                    state_d = INIT;
                end else if (let_v) begin
                    ec_d    = plug_q[let_code];
                    ev_d    = 1'b1;
                    state_d = CRYPT_WAIT;
                end
            end
            CRYPT_WAIT: begin
                if (enc_valid_out) begin
                    pa_v    = 1'b1;
                    pa_d    = 8'h41 + {3'b000, plug_q[enc_char_out]};
                    state_d = CRYPT;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_comb begin
        a_ok  = pa_v && !full;
        b_ok  = pb_v && ((cnt_q + (AW+1)'(a_ok)) < (AW+1)'(TXQ_DEPTH));
        pop   = (cnt_q != '0) && tx_ready && !txs_q;
        ovf_d = ovf_q | (pa_v & ~a_ok) | (pb_v & ~b_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ret_q   <= MENU;
            msg_q   <= MSG_MENU;
            idx_q   <= '0;
            l1_q    <= '0;
            rot_a_q <= '0;
            rot_b_q <= '0;
            rcnt_q  <= '0;
            pos1_q  <= '0;
            pos2_q  <= '0;
            pos3_q  <= '0;
            load_q  <= 1'b0;
            ev_q    <= 1'b0;
            ec_q    <= '0;
            pair_q  <= '0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            txs_q   <= 1'b0;
            txb_q   <= '0;
            for (int i = 0; i < 32; i++) plug_q[i] <= 5'(i);
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            msg_q   <= msg_d;
            idx_q   <= idx_d;
            l1_q    <= l1_d;
            rot_a_q <= rot_a_d;
            rot_b_q <= rot_b_d;
            rcnt_q  <= rcnt_d;
            pos1_q  <= pos1_d;
            pos2_q  <= pos2_d;
            pos3_q  <= pos3_d;
            load_q  <= load_d;
            ev_q    <= ev_d;
            ec_q    <= ec_d;
            pair_q  <= pair_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_q + AW'(a_ok) + AW'(b_ok);
            rd_q    <= rd_q + AW'(pop);
            cnt_q   <= cnt_q + (AW+1)'(a_ok) + (AW+1)'(b_ok) - (AW+1)'(pop);
            txs_q   <= pop;
            if (pop) txb_q <= mem_q[rd_q];
            if (plug_clr) begin
                for (int i = 0; i < 32; i++) plug_q[i] <= 5'(i);
            end else if (plug_set) begin
                plug_q[l1_q]     <= let_code;
                plug_q[let_code] <= l1_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (a_ok) mem_q[wr_q] <= pa_d;
        if (b_ok) mem_q[wr_q + AW'(a_ok)] <= pb_d;
    end

    assign tx_byte      = txb_q;
    assign tx_start     = txs_q;
    assign enc_char_in  = ec_q;
    assign enc_valid_in = ev_q;
    assign enc_pos1     = pos1_q;
    assign enc_pos2     = pos2_q;
    assign enc_pos3     = pos3_q;
    assign enc_load     = load_q;
    assign state_dbg    = state_q;
    assign pair_count   = pair_q;
    assign tx_ovf       = ovf_q;
endmodule

// File: tb/tb_consola_enigma.sv
// tb_consola_enigma: random console traffic against a byte-level model
// of the menu, plugboard, rotor setup and crypt round trip.
module tb_consola_enigma;
    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic       tx_ready;
    logic [7:0] tx_byte;
    logic       tx_start;
    logic [4:0] enc_char_in;
    logic       enc_valid_in;
    logic [4:0] enc_char_out;
    logic       enc_valid_out;
    logic [4:0] enc_pos1, enc_pos2, enc_pos3;
    logic       enc_load;
    logic [3:0] state_dbg;
    logic [3:0] pair_count;
    logic       tx_ovf;

    consola_enigma #(.TXQ_DEPTH(DEPTH), .ALPHA(26), .MAX_PAIRS(10)) dut (
        .clk(clk), .rst(rst),
        .rx_byte(rx_byte), .rx_done(rx_done), .tx_ready(tx_ready),
        .tx_byte(tx_byte), .tx_start(tx_start),
        .enc_char_in(enc_char_in), .enc_valid_in(enc_valid_in),
        .enc_char_out(enc_char_out), .enc_valid_out(enc_valid_out),
        .enc_pos1(enc_pos1), .enc_pos2(enc_pos2), .enc_pos3(enc_pos3),
        .enc_load(enc_load), .state_dbg(state_dbg),
        .pair_count(pair_count), .tx_ovf(tx_ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    bit          tx_prev = 1'b0;
    int          ev_cnt = 0;
    int          ld_cnt = 0;
    logic [4:0]  ev_char = '0;
    logic [14:0] ld_pos = '0;

    always @(posedge clk) begin
        #1;
        if (tx_start) begin
            got_q.push_back(tx_byte);
            chk("tx_gap", 32'(tx_prev), 0);
        end
        tx_prev = tx_start;
        if (enc_valid_in) begin
            ev_cnt++;
            ev_char = enc_char_in;
        end
        if (enc_load) begin
            ld_cnt++;
            ld_pos = {enc_pos1, enc_pos2, enc_pos3};
        end
    end

    // Model: mode codes equal the visible state codes when idle.
    int m_mode;
    int m_plug[26];
    int m_pairs;
    int m_l1;
    int m_rot[$];
    int m_pos[3];
    bit m_load;
    bit m_cpend;
    int m_cexp;

    task automatic put_msg(input string s);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    task automatic go_menu();
        put_msg("MENU>");
        m_mode = 2;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 26; i++) m_plug[i] = i;
        m_pairs = 0;
        m_rot.delete();
        for (int i = 0; i < 3; i++) m_pos[i] = 0;
        go_menu();
    endtask

    task automatic model_rx(input logic [7:0] b);
        bit isl;
        int c;
        isl = (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
        c = (b >= 8'h61) ? int'(b) - 'h61 : int'(b) - 'h41;
        m_load = 0;
        m_cpend = 0;
        case (m_mode)
            2: begin
                if (b == "P" || b == "p") begin
                    put_msg("PLUG:"); m_mode = 3;
                end else if (b == "R" || b == "r") begin
                    put_msg("ROT:"); m_rot.delete(); m_mode = 5;
                end else if (b == "S" || b == "s") begin
                    put_msg("CRYPT:"); m_mode = 6;
                end
            end
            3: begin
                if (b == 8'h1B) go_menu();
                else if (b == ".") begin
                    for (int i = 0; i < 26; i++) m_plug[i] = i;
                    m_pairs = 0;
                end else if (isl) begin
                    if (m_plug[c] != c || m_pairs == 10) exp_q.push_back("?");
                    else begin
                        exp_q.push_back(8'(8'h41 + c));
                        m_l1 = c;
                        m_mode = 4;
                    end
                end
            end
            4: begin
                if (b == 8'h1B) go_menu();
                else if (isl) begin
                    m_mode = 3;
                    if (c == m_l1 || m_plug[c] != c) exp_q.push_back("?");
                    else begin
                        exp_q.push_back(8'(8'h41 + c));
                        exp_q.push_back(" ");
                        m_plug[m_l1] = c;
                        m_plug[c] = m_l1;
                        m_pairs++;
                    end
                end
            end
            5: begin
                if (b == 8'h1B) go_menu();
                else if (isl) begin
                    exp_q.push_back(8'(8'h41 + c));
                    m_rot.push_back(c);
                    if (m_rot.size() == 3) begin
                        for (int i = 0; i < 3; i++) m_pos[i] = m_rot[i];
                        m_rot.delete();
                        m_load = 1;
                        go_menu();
                    end
                end
            end
            6: begin
                if (b == 8'h1B) go_menu();
                else if (isl) begin
                    m_cpend = 1;
                    m_cexp = m_plug[c];
                end
            end
            default: ;
        endcase
    endtask

    task automatic cmp_out();
        int n;
        chk("tx_len", got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk("tx_byte", got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic settle();
        for (int k = 0; k < 400 && got_q.size() < exp_q.size(); k++)
            @(negedge clk);
        repeat (30) @(negedge clk);
        cmp_out();
        chk("state", state_dbg, m_mode);
        chk("pairs", pair_count, m_pairs);
        chk("ovf", tx_ovf, 0);
        chk("pos", {enc_pos1, enc_pos2, enc_pos3},
            {5'(m_pos[0]), 5'(m_pos[1]), 5'(m_pos[2])});
    endtask

    task automatic drive(input logic [7:0] b);
        @(negedge clk);
        rx_byte = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int r);
        int ev0, ld0, rr;
        ev0 = ev_cnt;
        ld0 = ld_cnt;
        model_rx(b);
        drive(b);
        if (m_cpend) begin
            for (int k = 0; k < 10 && ev_cnt == ev0; k++) @(negedge clk);
            chk("enc_valid_in", ev_cnt - ev0, 1);
            chk("enc_char_in", ev_char, m_cexp);
            chk("st_wait", state_dbg, 7);
            drive(($urandom_range(1) == 1) ? 8'h1B : 8'h51);
            rr = (r < 0) ? int'($urandom_range(25)) : r;
            enc_char_out = 5'(rr);
            enc_valid_out = 1'b1;
            @(negedge clk);
            enc_valid_out = 1'b0;
            exp_q.push_back(8'(8'h41 + m_plug[rr]));
        end
        settle();
        chk("load_cnt", ld_cnt - ld0, 32'(m_load));
        if (m_load)
            chk("load_pos", ld_pos,
                {5'(m_pos[0]), 5'(m_pos[1]), 5'(m_pos[2])});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_done = 1'b0;
        @(negedge clk);
        chk("rst_state", state_dbg, 0);
        chk("rst_txs", tx_start, 0);
        chk("rst_txb", tx_byte, 0);
        chk("rst_ev", enc_valid_in, 0);
        chk("rst_ec", enc_char_in, 0);
        chk("rst_ld", enc_load, 0);
        chk("rst_pos", {enc_pos1, enc_pos2, enc_pos3}, 0);
        chk("rst_pairs", pair_count, 0);
        chk("rst_ovf", tx_ovf, 0);
        got_q.delete();
        exp_q.delete();
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [7:0] b;
        int k;
        rst = 1'b1;
        rx_byte = '0;
        rx_done = 1'b0;
        tx_ready = 1'b1;
        enc_char_out = '0;
        enc_valid_out = 1'b0;
        repeat (3) @(negedge clk);

        do_reset();
        settle();

        send("P", -1); send("a", -1); send("b", -1);
        send(8'h1B, -1); send("S", -1); send("A", 0);
        send(8'h1B, -1); send("P", -1); send("B", -1);
        send(".", -1); send("b", -1); send("c", -1);
        send(8'h1B, -1);
        send("R", -1); send("Q", -1); send("E", -1); send("V", -1);

        do_reset();
        settle();
        tx_ready = 1'b0;
        drive("P");
        repeat (12) @(negedge clk);
        for (int i = 0; i < 20; i++) drive((i % 2 == 1) ? "?" : "A");
        repeat (4) @(negedge clk);
        chk("ovf_set", tx_ovf, 1);
        chk("st_x", 32'($isunknown(state_dbg)), 0);
        chk("st_plug1", state_dbg, 3);
        got_q.delete();
        exp_q.delete();
        put_msg("PLUG:");
        for (int i = 0; i < 9; i++) exp_q.push_back((i % 2 == 1) ? "?" : "A");
        tx_ready = 1'b1;
        repeat (100) @(negedge clk);
        chk("drain_len", got_q.size(), DEPTH);
        cmp_out();
        chk("ovf_sticky", tx_ovf, 1);

        do_reset();
        for (int i = 0; i < 100 && got_q.size() < 3; i++) @(negedge clk);
        chk("pre_abort", 32'(got_q.size() >= 3), 1);
        do_reset();
        settle();

        for (int n = 0; n < 300; n++) begin
            k = int'($urandom_range(15));
            case (k)
                0: b = 8'h1B;
                1: b = ".";
                2: b = "?";
                3: b = ($urandom_range(1) == 1) ? "P" : "p";
                4: b = ($urandom_range(1) == 1) ? "R" : "r";
                5: b = ($urandom_range(1) == 1) ? "S" : "s";
                default: b = 8'($urandom_range(25)) +
                             (($urandom_range(1) == 1) ? 8'h41 : 8'h61);
            endcase
            send(b, -1);
            if ($urandom_range(7) == 0) begin
                @(negedge clk);
                enc_char_out = 5'($urandom_range(25));
                enc_valid_out = 1'b1;
                @(negedge clk);
                enc_valid_out = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
        settle();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
